// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard unit.
//   FWD_NONE / FWD_MEMWB / FWD_EXMEM : 2-bit forwarding-mux select codes
//   state_t                          : control-hazard FSM states
// Optional feature macro used elsewhere in the slice: HAZARD_PERF_EN
package hazard_pkg;

    localparam logic [1:0] FWD_NONE  = 2'b00;
    localparam logic [1:0] FWD_MEMWB = 2'b01;
    localparam logic [1:0] FWD_EXMEM = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the hazard unit.
//   master : pipeline side, drives ID/EX/MEM/WB register info, reads hazard decisions
//   slave  : hazard unit side
// Port summary:
//   ID  : id_valid, id_src_num, id_src_use, id_is_ctrl
//   EX  : ex_src_num, ex_wr_en, ex_wr_num, ex_mem_rd
//   MEM : mem_wr_en, mem_wr_num     WB : wb_wr_en, wb_wr_num
//   resolve stage : rs_taken
//   decisions : fwd_sel, stall_pc, stall_ifid, flush, ctrl_busy
// With HAZARD_PERF_EN defined, perf_stall_cnt and perf_flush_cnt are added.
interface hazard_ctrl_if #(
    parameter int NUM_REGS    = 8,
    parameter int NUM_SRC     = 2,
    parameter int RESOLVE_LAT = 1
);
    localparam int RA_W = $clog2(NUM_REGS);

    logic                      id_valid;
    logic [NUM_SRC*RA_W-1:0]   id_src_num;
    logic [NUM_SRC-1:0]        id_src_use;
    logic                      id_is_ctrl;
    logic [NUM_SRC*RA_W-1:0]   ex_src_num;
    logic                      ex_wr_en;
    logic [RA_W-1:0]           ex_wr_num;
    logic                      ex_mem_rd;
    logic                      mem_wr_en;
    logic [RA_W-1:0]           mem_wr_num;
    logic                      wb_wr_en;
    logic [RA_W-1:0]           wb_wr_num;
    logic                      rs_taken;
    logic [2*NUM_SRC-1:0]      fwd_sel;
    logic                      stall_pc;
    logic                      stall_ifid;
    logic [RESOLVE_LAT:0]      flush;
    logic                      ctrl_busy;
`ifdef HAZARD_PERF_EN
    logic [31:0]               perf_stall_cnt;
    logic [31:0]               perf_flush_cnt;
`endif

    modport master (
        output id_valid, id_src_num, id_src_use, id_is_ctrl,
        output ex_src_num, ex_wr_en, ex_wr_num, ex_mem_rd,
        output mem_wr_en, mem_wr_num, wb_wr_en, wb_wr_num, rs_taken,
        input  fwd_sel, stall_pc, stall_ifid, flush, ctrl_busy
`ifdef HAZARD_PERF_EN
        , input perf_stall_cnt, perf_flush_cnt
`endif
    );

    modport slave (
        input  id_valid, id_src_num, id_src_use, id_is_ctrl,
        input  ex_src_num, ex_wr_en, ex_wr_num, ex_mem_rd,
        input  mem_wr_en, mem_wr_num, wb_wr_en, wb_wr_num, rs_taken,
        output fwd_sel, stall_pc, stall_ifid, flush, ctrl_busy
`ifdef HAZARD_PERF_EN
        , output perf_stall_cnt, perf_flush_cnt
`endif
    );

endinterface

// File: rtl/hazard_fwd_cmp.sv
// Forwarding select for one EX-stage source operand.
// Ports:
//   src_num    in  RA_W  EX source register number
//   mem_wr_en  in  1     EX/MEM writes a register
//   mem_wr_num in  RA_W  EX/MEM destination
//   wb_wr_en   in  1     MEM/WB writes a register
//   wb_wr_num  in  RA_W  MEM/WB destination
//   sel        out 2     FWD_EXMEM / FWD_MEMWB / FWD_NONE
module hazard_fwd_cmp
    import hazard_pkg::*;
#(
    parameter int RA_W = 3
) (
    input  logic [RA_W-1:0] src_num,
    input  logic            mem_wr_en,
    input  logic [RA_W-1:0] mem_wr_num,
    input  logic            wb_wr_en,
    input  logic [RA_W-1:0] wb_wr_num,
    output logic [1:0]      sel
);

    logic mem_hit;
    logic wb_hit;

    // R0 is an ordinary register here, so no zero-register exclusion.
    assign mem_hit = mem_wr_en && (mem_wr_num == src_num);
    assign wb_hit  = wb_wr_en  && (wb_wr_num  == src_num);

    // The younger result (EX/MEM) wins when both stages write the same register.
    always_comb begin
        sel = FWD_NONE;
        if (mem_hit) begin
            sel = FWD_EXMEM;
        end else if (wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard unit for the 5-stage pipe: EX operand forwarding, load-use stall and
// control-hazard handling (stall-until-resolve or predict-not-taken).
// Ports:
//   clk  in  clock
//   rst  in  asynchronous active-high reset
//   hz   hazard_ctrl_if.slave (pipeline register info in, hazard decisions out)
// Parameters: NUM_REGS, NUM_SRC, RESOLVE_LAT (1..3), PRED_NT (0 stall, 1 predict not-taken)
// Optional macro HAZARD_PERF_EN adds saturating stall-cycle and taken-flush counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_REGS    = 8,
    parameter int NUM_SRC     = 2,
    parameter int RESOLVE_LAT = 1,
    parameter int PRED_NT     = 0
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    localparam int RA_W  = $clog2(NUM_REGS);
    localparam int CNT_W = $clog2(RESOLVE_LAT + 1);
    localparam int FL_W  = RESOLVE_LAT + 1;

    state_t               state;
    state_t               state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [NUM_SRC-1:0]   src_hit;
    logic [2*NUM_SRC-1:0] fwd_sel;
    logic                 load_use;
    logic                 ctrl_in_id;
    logic                 resolve;
    logic                 taken_flush;
    logic                 stall_pc;
    logic                 stall_ifid;
    logic [FL_W-1:0]      flush;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        hazard_fwd_cmp #(
            .RA_W (RA_W)
        ) u_fwd_cmp (
            .src_num    (hz.ex_src_num[i*RA_W +: RA_W]),
            .mem_wr_en  (hz.mem_wr_en),
            .mem_wr_num (hz.mem_wr_num),
            .wb_wr_en   (hz.wb_wr_en),
            .wb_wr_num  (hz.wb_wr_num),
            .sel        (fwd_sel[2*i +: 2])
        );

        assign src_hit[i] = hz.id_src_use[i] &&
                            (hz.id_src_num[i*RA_W +: RA_W] == hz.ex_wr_num);
    end

    assign load_use    = hz.ex_mem_rd && hz.ex_wr_en && hz.id_valid && (|src_hit);
    assign ctrl_in_id  = hz.id_valid && hz.id_is_ctrl;
    // Last WAIT cycle: the branch/jump is now in its resolve stage.
    assign resolve     = (state == WAIT) && (cnt == CNT_W'(1));
    assign taken_flush = (PRED_NT != 0) && resolve && hz.rs_taken;

    // State register; reset may arrive mid-WAIT and simply abandons the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Entry is deferred while a load-use stall holds the control instruction in ID.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (ctrl_in_id && !load_use) begin
                    state_nxt = WAIT;
                    cnt_nxt   = CNT_W'(RESOLVE_LAT);
                end
            end
            WAIT: begin
                if (resolve) begin
                    state_nxt = IDLE;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
    end

    // Decision priority: taken-flush, then load-use, then control stall.
    // A load-use hold of IF/ID overrides the control squash of IF/ID.
    always_comb begin
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush      = '0;
        if (!rst) begin
            if (taken_flush) begin
                flush = '1;
            end else if (load_use) begin
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
                flush[1]   = 1'b1;
            end else if (PRED_NT == 0) begin
                if (state == WAIT) begin
                    stall_pc = !resolve;
                    flush[0] = 1'b1;
                end else if (ctrl_in_id) begin
                    stall_pc = 1'b1;
                    flush[0] = 1'b1;
                end
            end else begin
                // Only one control instruction may be outstanding; a second one waits in ID.
                if ((state == WAIT) && ctrl_in_id) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    flush[1]   = 1'b1;
                end
            end
        end
    end

    assign hz.fwd_sel    = fwd_sel;
    assign hz.stall_pc   = stall_pc;
    assign hz.stall_ifid = stall_ifid;
    assign hz.flush      = flush;
    assign hz.ctrl_busy  = (state == WAIT);

`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;

    // Saturating event counters for stall cycles and taken-branch flushes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall <= '0;
            perf_flush <= '0;
        end else begin
            if (stall_pc && (perf_stall != 32'hFFFF_FFFF)) begin
                perf_stall <= perf_stall + 32'd1;
            end
            if (taken_flush && (perf_flush != 32'hFFFF_FFFF)) begin
                perf_flush <= perf_flush + 32'd1;
            end
        end
    end

    assign hz.perf_stall_cnt = perf_stall;
    assign hz.perf_flush_cnt = perf_flush;
`endif

endmodule
